// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues operands and a start request; the slave side
// (the subtractor) returns the difference, borrow-out and status flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             valid;

    modport master (
        output start, a, b, bin,
        input  diff, bout, busy, valid
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, busy, valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// A start in IDLE latches the operands; WIDTH RUN cycles ripple the borrow
// through the bits, then a single DONE cycle pulses valid. diff and bout
// keep the last result until the next accepted start.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_subtractor_if.slave bus
);

    // Bit counter needs to index 0..WIDTH-1, but never narrower than one bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             bout_q;
    logic             busy_q;
    logic             valid_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;

    // One-bit full subtractor on the bit currently selected by the counter.
    always_comb begin
        a_bit   = a_q[cnt];
        b_bit   = b_q[cnt];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    // Control FSM plus datapath registers; busy/valid are registered so they
    // track the state exactly and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            br      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        br     <= bus.bin;
                        diff_q <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff_q[cnt] <= d_bit;
                    br          <= br_next;
                    if (cnt == LAST) begin
                        bout_q  <= br_next;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit and a 1-bit instance.
// Stimulus pushes hand-computed results into per-instance queues; monitors
// pop and compare whenever valid is seen.
module tb_serial_subtractor;

    logic clk;
    logic rst;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
    } exp8_t;

    exp8_t      q8[$];
    logic [1:0] q1[$];

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any failure.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for the 8-bit instance: every valid must match the queue head.
    always @(negedge clk) begin
        exp8_t e;
        if (bus8.valid === 1'b1) begin
            if (q8.size() == 0) begin
                checkOutput("unexpected_valid8", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("diff8", 64'(bus8.diff), 64'(e.diff));
                checkOutput("bout8", 64'(bus8.bout), 64'(e.bout));
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (bus1.valid === 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("unexpected_valid1", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                checkOutput("diff1", 64'(bus1.diff), 64'(e[1]));
                checkOutput("bout1", 64'(bus1.bout), 64'(e[0]));
            end
        end
    end

    // Issue one 8-bit operation, optionally poking a stray start during RUN,
    // and check latency, busy duration, diff clear and result hold.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                 input logic [7:0] exp_diff, input logic exp_bout,
                                 input int poke_cycle);
        int  cycles;
        int  busy_cnt;
        bit  seen;
        exp8_t e;
        @(negedge clk);
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        e.diff = exp_diff;
        e.bout = exp_bout;
        q8.push_back(e);
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.bin   = ~bin;
        cycles   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) checkOutput("diff_cleared8", 64'(bus8.diff), 64'd0);
            if (poke_cycle != 0 && cycles == poke_cycle) begin
                bus8.a     = 8'h10;
                bus8.b     = 8'h01;
                bus8.bin   = 1'b0;
                bus8.start = 1'b1;
            end
            if (poke_cycle != 0 && cycles == poke_cycle + 1) bus8.start = 1'b0;
            if (bus8.busy === 1'b1) busy_cnt++;
            if (bus8.valid === 1'b1) seen = 1'b1;
        end
        bus8.start = 1'b0;
        checkOutput("latency8", 64'(cycles), 64'd9);
        checkOutput("busy_cycles8", 64'(busy_cnt), 64'd8);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_diff8", 64'(bus8.diff), 64'(exp_diff));
        checkOutput("hold_bout8", 64'(bus8.bout), 64'(exp_bout));
        checkOutput("idle_busy8", 64'(bus8.busy), 64'd0);
    endtask

    // Issue one 1-bit operation and check its two-cycle latency.
    task automatic applyStimulus1(input logic a, input logic b, input logic bin,
                                  input logic [1:0] exp_db);
        int cycles;
        bit seen;
        @(negedge clk);
        bus1.a     = a;
        bus1.b     = b;
        bus1.bin   = bin;
        bus1.start = 1'b1;
        q1.push_back(exp_db);
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus1.a     = ~a;
        bus1.b     = ~b;
        bus1.bin   = ~bin;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) checkOutput("busy1", 64'(bus1.busy), 64'd1);
            if (bus1.valid === 1'b1) seen = 1'b1;
        end
        checkOutput("latency1", 64'(cycles), 64'd2);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [15:0] w1_table;
        int          busy_seen;
        checks = 0;
        errors = 0;

        rst        = 1'b1;
        bus8.start = 1'b1;
        bus8.a     = 8'h0F;
        bus8.b     = 8'h01;
        bus8.bin   = 1'b0;
        bus1.start = 1'b1;
        bus1.a     = 1'b1;
        bus1.b     = 1'b0;
        bus1.bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy8", 64'(bus8.busy), 64'd0);
        checkOutput("reset_valid8", 64'(bus8.valid), 64'd0);
        checkOutput("reset_diff8", 64'(bus8.diff), 64'd0);
        checkOutput("reset_bout8", 64'(bus8.bout), 64'd0);
        checkOutput("reset_busy1", 64'(bus1.busy), 64'd0);
        rst        = 1'b0;
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        @(negedge clk);
        checkOutput("start_with_rst_ignored", 64'(bus8.busy), 64'd0);

        $display("[TB] 8-bit directed vectors");
        applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0);
        applyStimulus(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 0);
        applyStimulus(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 0);
        applyStimulus(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 0);

        $display("[TB] stray start during RUN");
        applyStimulus(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 3);
        repeat (15) @(negedge clk);
        checkOutput("stray_start_not_queued", 64'(bus8.busy), 64'd0);

        $display("[TB] reset in the middle of RUN");
        @(negedge clk);
        bus8.a     = 8'hFF;
        bus8.b     = 8'h00;
        bus8.bin   = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_rst_busy8", 64'(bus8.busy), 64'd0);
        checkOutput("midrun_rst_diff8", 64'(bus8.diff), 64'd0);
        checkOutput("midrun_rst_bout8", 64'(bus8.bout), 64'd0);
        checkOutput("midrun_rst_valid8", 64'(bus8.valid), 64'd0);
        rst = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.busy === 1'b1) busy_seen++;
        end
        checkOutput("discarded_op_stays_idle", 64'(busy_seen), 64'd0);
        applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0);

        $display("[TB] 1-bit exhaustive table");
        w1_table = 16'b00_11_11_01_10_00_00_11;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            applyStimulus1(abc[2], abc[1], abc[0], w1_table[15 - 2 * i -: 2]);
        end

        repeat (20) @(negedge clk);
        checkOutput("queue8_drained", 64'(q8.size()), 64'd0);
        checkOutput("queue1_drained", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
